// File: rtl/adder_axis_tree.sv
// N-operand AXI-Stream adder: joins NUM_OPERANDS input streams and sums them in a
// registered pairwise tree with per-level valid/ready flow control and overflow-aware output.
`timescale 1ns / 1ps
module adder_axis_tree #(
  parameter int unsigned NUM_OPERANDS = 4,
  parameter int unsigned IN_WIDTH     = 8,
  parameter int unsigned OUT_WIDTH    = IN_WIDTH + $clog2(NUM_OPERANDS),
  parameter bit          SIGNED       = 1'b0,
  parameter bit          SATURATE     = 1'b0
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  input  logic [NUM_OPERANDS*IN_WIDTH-1:0] s_tdata,
  input  logic [NUM_OPERANDS-1:0]          s_tvalid,
  output logic [NUM_OPERANDS-1:0]          s_tready,
  output logic [OUT_WIDTH-1:0]             m_tdata,
  output logic                             m_tvalid,
  input  logic                             m_tready,
  output logic                             m_tuser
);

  localparam int unsigned FW  = IN_WIDTH + $clog2(NUM_OPERANDS);
  localparam int unsigned LAT = (NUM_OPERANDS > 2) ? $clog2(NUM_OPERANDS) : 1;
  localparam int unsigned W1  = (NUM_OPERANDS + 1) / 2;
  localparam int unsigned NP  = 2 * W1;
  localparam int unsigned MID = (LAT > 1) ? LAT - 1 : 1;
  localparam int unsigned MW  = (OUT_WIDTH > FW) ? OUT_WIDTH : FW;

  if (NUM_OPERANDS < 2 || NUM_OPERANDS > 8) begin : g_bad_num_operands
    $fatal(1, "adder_axis_tree: NUM_OPERANDS must be in 2..8");
  end

  typedef logic [FW-1:0]        fw_t;
  typedef logic [MW-1:0]        mw_t;
  typedef logic [OUT_WIDTH-1:0] out_t;
  typedef logic [LAT-1:0]       lat_t;

  fw_t            op     [NP];
  fw_t            sum_d  [LAT][W1];
  fw_t            mid_q  [MID][W1];
  logic [LAT-1:0] vld_q;
  logic [LAT-1:0] vld_up;
  logic [LAT-1:0] stage_rdy;
  logic           join_fire;
  out_t           conv_data;
  logic           conv_ovf;
  out_t           m_tdata_q;
  logic           m_tuser_q;

  always_comb begin : p_extend
    for (int unsigned i = 0; i < NP; i++) op[i] = '0;
    for (int unsigned i = 0; i < NUM_OPERANDS; i++) begin
      if (SIGNED) op[i] = fw_t'($signed(s_tdata[i*IN_WIDTH +: IN_WIDTH]));
      else        op[i] = fw_t'(s_tdata[i*IN_WIDTH +: IN_WIDTH]);
    end
  end

  // Level k+1 sums adjacent entries of level k; an odd tail entry passes through unchanged.
  always_comb begin : p_tree
    fw_t         src [NP];
    int unsigned cnt;
    int unsigned mk;
    cnt = NUM_OPERANDS;
    for (int unsigned k = 0; k < LAT; k++) begin
      mk = (k == 0) ? 0 : k - 1;
      for (int unsigned i = 0; i < NP; i++) src[i] = (k == 0) ? op[i] : '0;
      if (k != 0) begin
        for (int unsigned i = 0; i < W1; i++) src[i] = mid_q[mk][i];
      end
      for (int unsigned j = 0; j < W1; j++) begin
        sum_d[k][j] = '0;
        if (2 * j + 1 < cnt)  sum_d[k][j] = src[2*j] + src[2*j+1];
        else if (2 * j < cnt) sum_d[k][j] = src[2*j];
      end
      cnt = (cnt + 1) / 2;
    end
  end

  // A level may load when it is empty or the level after it is loading too.
  always_comb begin : p_ready
    logic r;
    r = m_tready;
    for (int k = LAT - 1; k >= 0; k--) begin
      r = !vld_q[k] || r;
      stage_rdy[k] = r;
    end
  end

  assign join_fire = aresetn && (&s_tvalid) && stage_rdy[0];
  assign s_tready  = {NUM_OPERANDS{join_fire}};
  assign vld_up    = lat_t'({vld_q, join_fire});

  // Representability is checked by truncating and re-extending; a round-trip change means overflow.
  always_comb begin : p_convert
    mw_t  sx;
    mw_t  back;
    out_t wrap;
    if (SIGNED) sx = mw_t'($signed(sum_d[LAT-1][0]));
    else        sx = mw_t'(sum_d[LAT-1][0]);
    wrap = out_t'(sx);
    if (SIGNED) back = mw_t'($signed(wrap));
    else        back = mw_t'(wrap);
    conv_ovf  = (back != sx);
    conv_data = wrap;
    if (conv_ovf && SATURATE) begin
      if (!SIGNED)        conv_data = '1;
      else if (sx[MW-1])  conv_data = out_t'(1) << (OUT_WIDTH - 1);
      else                conv_data = ~(out_t'(1) << (OUT_WIDTH - 1));
    end
  end

  always_ff @(posedge aclk) begin : p_ctrl
    if (!aresetn) begin
      vld_q     <= '0;
      m_tdata_q <= '0;
      m_tuser_q <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < LAT; k++) begin
        if (stage_rdy[k]) vld_q[k] <= vld_up[k];
      end
      if (stage_rdy[LAT-1] && vld_up[LAT-1]) begin
        m_tdata_q <= conv_data;
        m_tuser_q <= conv_ovf;
      end
    end
  end

  always_ff @(posedge aclk) begin : p_mid
    for (int unsigned k = 0; k + 1 < LAT; k++) begin
      if (stage_rdy[k] && vld_up[k]) mid_q[k] <= sum_d[k];
    end
  end

  assign m_tvalid = vld_q[LAT-1];
  assign m_tdata  = m_tdata_q;
  assign m_tuser  = m_tuser_q;

endmodule

// File: tb/tb_adder_axis_tree.sv
// Directed bench for adder_axis_tree across several parameterisations sharing one clock/reset.
`timescale 1ns / 1ps
module tb_adder_axis_tree;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // N=4 unsigned, OUT=10
  logic [31:0] bas_tdata;
  logic [3:0]  bas_tvalid, bas_tready;
  logic [9:0]  bas_mdata;
  logic        bas_mvalid, bas_mready, bas_muser;
  // N=4 signed saturate, OUT=8
  logic [31:0] sat_tdata;
  logic [3:0]  sat_tvalid, sat_tready;
  logic [7:0]  sat_mdata;
  logic        sat_mvalid, sat_mready, sat_muser;
  // N=4 unsigned wrap, OUT=8
  logic [31:0] wrp_tdata;
  logic [3:0]  wrp_tvalid, wrp_tready;
  logic [7:0]  wrp_mdata;
  logic        wrp_mvalid, wrp_mready, wrp_muser;
  // N=3 unsigned, OUT=10
  logic [23:0] thr_tdata;
  logic [2:0]  thr_tvalid, thr_tready;
  logic [9:0]  thr_mdata;
  logic        thr_mvalid, thr_mready, thr_muser;
  // N=8 unsigned, OUT=11
  logic [63:0] oct_tdata;
  logic [7:0]  oct_tvalid, oct_tready;
  logic [10:0] oct_mdata;
  logic        oct_mvalid, oct_mready, oct_muser;

  adder_axis_tree #(.NUM_OPERANDS(4), .IN_WIDTH(8)) u_bas (
    .aclk(clk), .aresetn(rst_n), .s_tdata(bas_tdata), .s_tvalid(bas_tvalid),
    .s_tready(bas_tready), .m_tdata(bas_mdata), .m_tvalid(bas_mvalid), .m_tready(bas_mready),
    .m_tuser(bas_muser));

  adder_axis_tree #(.NUM_OPERANDS(4), .IN_WIDTH(8), .OUT_WIDTH(8), .SIGNED(1'b1),
                    .SATURATE(1'b1)) u_sat (
    .aclk(clk), .aresetn(rst_n), .s_tdata(sat_tdata), .s_tvalid(sat_tvalid),
    .s_tready(sat_tready), .m_tdata(sat_mdata), .m_tvalid(sat_mvalid), .m_tready(sat_mready),
    .m_tuser(sat_muser));

  adder_axis_tree #(.NUM_OPERANDS(4), .IN_WIDTH(8), .OUT_WIDTH(8), .SIGNED(1'b0),
                    .SATURATE(1'b0)) u_wrp (
    .aclk(clk), .aresetn(rst_n), .s_tdata(wrp_tdata), .s_tvalid(wrp_tvalid),
    .s_tready(wrp_tready), .m_tdata(wrp_mdata), .m_tvalid(wrp_mvalid), .m_tready(wrp_mready),
    .m_tuser(wrp_muser));

  adder_axis_tree #(.NUM_OPERANDS(3), .IN_WIDTH(8)) u_thr (
    .aclk(clk), .aresetn(rst_n), .s_tdata(thr_tdata), .s_tvalid(thr_tvalid),
    .s_tready(thr_tready), .m_tdata(thr_mdata), .m_tvalid(thr_mvalid), .m_tready(thr_mready),
    .m_tuser(thr_muser));

  adder_axis_tree #(.NUM_OPERANDS(8), .IN_WIDTH(8)) u_oct (
    .aclk(clk), .aresetn(rst_n), .s_tdata(oct_tdata), .s_tvalid(oct_tvalid),
    .s_tready(oct_tready), .m_tdata(oct_mdata), .m_tvalid(oct_mvalid), .m_tready(oct_mready),
    .m_tuser(oct_muser));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] sat_vec [5];
  logic [7:0]  sat_exp [5];
  logic        sat_ovf [5];
  logic [31:0] wrp_vec [3];
  logic [7:0]  wrp_exp [3];
  logic        wrp_ovf [3];
  logic [63:0] rdy_pat;
  int          tx, rx, held;
  logic        stall_prev, in_hs, out_hs;

  initial begin
    sat_vec = '{32'h64646464, 32'h9c9c9c9c, 32'h0203fb0a, 32'h00000080, 32'h0000017f};
    sat_exp = '{8'h7f, 8'h80, 8'h0a, 8'h80, 8'h7f};
    sat_ovf = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    wrp_vec = '{32'hc8c8c8c8, 32'h000000ff, 32'h000001ff};
    wrp_exp = '{8'h20, 8'hff, 8'h00};
    wrp_ovf = '{1'b1, 1'b0, 1'b1};
    rdy_pat = 64'hFFFF_FFF0_5A3C_1F07;

    rst_n = 1'b0;
    bas_tdata = '0; sat_tdata = '0; wrp_tdata = '0; thr_tdata = '0; oct_tdata = '0;
    bas_tvalid = 4'hf; sat_tvalid = '0; wrp_tvalid = '0; thr_tvalid = '0; oct_tvalid = '0;
    bas_mready = 1'b1; sat_mready = 1'b1; wrp_mready = 1'b1; thr_mready = 1'b1;
    oct_mready = 1'b1;

    // Reset state
    step(); step();
    chk("rst_tready", 32'(bas_tready), 32'h0);
    chk("rst_mvalid", 32'(bas_mvalid), 32'h0);
    chk("rst_mdata", 32'(bas_mdata), 32'h0);
    chk("rst_muser", 32'(bas_muser), 32'h0);
    chk("rst_oct_mvalid", 32'(oct_mvalid), 32'h0);
    bas_tvalid = 4'h0;
    rst_n = 1'b1;
    step();

    // Basic sum 1+2+3+4, latency 2
    bas_tdata = 32'h04030201; bas_tvalid = 4'hf;
    #1 chk("basic_tready", 32'(bas_tready), 32'hf);
    step();
    bas_tvalid = 4'h0;
    chk("basic_lat1_mvalid", 32'(bas_mvalid), 32'h0);
    step();
    chk("basic_mvalid", 32'(bas_mvalid), 32'h1);
    chk("basic_mdata", 32'(bas_mdata), 32'd10);
    chk("basic_muser", 32'(bas_muser), 32'h0);
    step();
    chk("basic_drain", 32'(bas_mvalid), 32'h0);

    // Signed saturation, back-to-back
    sat_tvalid = 4'hf;
    for (int i = 0; i < 5; i++) begin
      sat_tdata = sat_vec[i];
      #1 chk("sat_tready", 32'(sat_tready), 32'hf);
      step();
      if (i > 0) begin
        chk("sat_mvalid", 32'(sat_mvalid), 32'h1);
        chk("sat_mdata", 32'(sat_mdata), 32'(sat_exp[i-1]));
        chk("sat_muser", 32'(sat_muser), 32'(sat_ovf[i-1]));
      end
    end
    sat_tvalid = 4'h0;
    step();
    chk("sat_last_mdata", 32'(sat_mdata), 32'(sat_exp[4]));
    chk("sat_last_muser", 32'(sat_muser), 32'(sat_ovf[4]));
    step();
    chk("sat_drain", 32'(sat_mvalid), 32'h0);

    // Unsigned wrap, back-to-back
    wrp_tvalid = 4'hf;
    for (int i = 0; i < 3; i++) begin
      wrp_tdata = wrp_vec[i];
      step();
      if (i > 0) begin
        chk("wrap_mvalid", 32'(wrp_mvalid), 32'h1);
        chk("wrap_mdata", 32'(wrp_mdata), 32'(wrp_exp[i-1]));
        chk("wrap_muser", 32'(wrp_muser), 32'(wrp_ovf[i-1]));
      end
    end
    wrp_tvalid = 4'h0;
    step();
    chk("wrap_last_mdata", 32'(wrp_mdata), 32'(wrp_exp[2]));
    chk("wrap_last_muser", 32'(wrp_muser), 32'(wrp_ovf[2]));

    // Join stall on N=3, then one handshake of 10+20+30
    thr_tdata = {8'd30, 8'd20, 8'd10}; thr_tvalid = 3'b011;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("stall_tready", 32'(thr_tready), 32'h0);
      chk("stall_mvalid", 32'(thr_mvalid), 32'h0);
    end
    thr_tvalid = 3'b111;
    #1 chk("join_tready", 32'(thr_tready), 32'h7);
    step();
    thr_tvalid = 3'b000;
    #1 chk("join_after_tready", 32'(thr_tready), 32'h0);
    chk("join_lat1_mvalid", 32'(thr_mvalid), 32'h0);
    step();
    chk("join_mvalid", 32'(thr_mvalid), 32'h1);
    chk("join_mdata", 32'(thr_mdata), 32'd60);
    chk("join_muser", 32'(thr_muser), 32'h0);
    step();
    chk("join_single", 32'(thr_mvalid), 32'h0);

    // Fill N=4 pipeline under backpressure, then reset mid-stream
    bas_mready = 1'b0; bas_tdata = 32'h04030201; bas_tvalid = 4'hf;
    step();
    bas_tdata = 32'h08070605;
    step();
    chk("full_mvalid", 32'(bas_mvalid), 32'h1);
    chk("full_mdata", 32'(bas_mdata), 32'd10);
    #1 chk("full_tready", 32'(bas_tready), 32'h0);
    bas_mready = 1'b1;
    #1 chk("full_release_tready", 32'(bas_tready), 32'hf);
    bas_mready = 1'b0; bas_tvalid = 4'h0; rst_n = 1'b0;
    step();
    chk("midrst_mvalid", 32'(bas_mvalid), 32'h0);
    chk("midrst_mdata", 32'(bas_mdata), 32'h0);
    bas_tvalid = 4'hf;
    #1 chk("midrst_tready", 32'(bas_tready), 32'h0);
    rst_n = 1'b1; bas_mready = 1'b1; bas_tdata = 32'h09090909;
    #1 chk("postrst_tready", 32'(bas_tready), 32'hf);
    step();
    bas_tvalid = 4'h0;
    chk("postrst_nostale", 32'(bas_mvalid), 32'h0);
    step();
    chk("postrst_mvalid", 32'(bas_mvalid), 32'h1);
    chk("postrst_mdata", 32'(bas_mdata), 32'd36);
    step();
    chk("postrst_drain", 32'(bas_mvalid), 32'h0);

    // N=8 backpressure: 20 transactions, operand i of transaction t is t+i
    tx = 0; rx = 0; held = 0; stall_prev = 1'b0;
    for (int c = 0; c < 200 && rx < 20; c++) begin
      oct_mready = (c < 64) ? rdy_pat[c] : 1'b1;
      for (int i = 0; i < 8; i++) oct_tdata[i*8 +: 8] = 8'(tx + i);
      oct_tvalid = (tx < 20) ? 8'hff : 8'h00;
      #1;
      if (stall_prev) chk("bp_hold_valid", 32'(oct_mvalid), 32'h1);
      if (tx < 20) begin
        chk("bp_tready", 32'(oct_tready), (held < 3 || oct_mready) ? 32'hff : 32'h0);
      end
      if (oct_mvalid) chk("bp_mdata", 32'(oct_mdata), 32'(8 * rx + 28));
      in_hs  = (tx < 20) && (oct_tready == 8'hff);
      out_hs = oct_mvalid && oct_mready;
      if (in_hs) begin
        tx++;
        held++;
      end
      if (out_hs) begin
        rx++;
        held--;
      end
      stall_prev = oct_mvalid && !oct_mready;
      step();
    end
    chk("bp_count", 32'(rx), 32'd20);
    oct_tvalid = 8'h00;
    step();
    chk("bp_no_extra", 32'(oct_mvalid), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adder_axis_tree.md
# adder_axis_tree

Parametrised N-operand AXI-Stream adder. It joins NUM_OPERANDS slave streams into one transaction and sums them in a registered adder tree. The result goes out on one master stream at one transaction per cycle, with full backpressure. It is the multi-operand, overflow-aware successor to the two-operand pipelined adder and sits in the same AXIS datapath.

## Interface
- NUM_OPERANDS, 4: number of input streams; legal range 2..8; elaboration `$fatal` outside the range.
- IN_WIDTH, 8: tdata width of each input stream.
- OUT_WIDTH, IN_WIDTH+$clog2(NUM_OPERANDS): output tdata width.
- SIGNED, 0: 1 means operands and result are two's complement; 0 means unsigned.
- SATURATE, 0: applies when OUT_WIDTH < full width. 1 means clip to the OUT_WIDTH range; 0 means wrap (keep LSBs).
- aclk  in  1  single clock, rising edge.
- aresetn  in  1  reset; synchronous and active-low.
- s_tdata  in  NUM_OPERANDS*IN_WIDTH  operand i occupies bits [i*IN_WIDTH +: IN_WIDTH].
- s_tvalid  in  NUM_OPERANDS  per-operand valid.
- s_tready  out  NUM_OPERANDS  per-operand ready.
- m_tdata  out  OUT_WIDTH  sum.
- m_tvalid  out  1  result valid.
- m_tready  in  1  downstream ready.
- m_tuser  out  1  overflow flag; 1 when the result was wrapped or clipped.

## Operation
- Full width: FW = IN_WIDTH+$clog2(NUM_OPERANDS). All internal sums are computed at FW, sign-extended if SIGNED else zero-extended, so no internal overflow is possible.
- Join:
  - join_fire = &s_tvalid && stage0_ready.
  - All s_tready[i] = join_fire. A lone valid operand is never consumed.
  - s_tready may depend on s_tvalid; no output valid depends on any ready.
- Tree:
  - LAT = max(1, $clog2(NUM_OPERANDS)) levels, each registered.
  - Level k pairs adjacent entries of level k-1. An odd leftover is passed through registered, unchanged.
  - The final level is the output register.
- Stage flow control:
  - Each level has a valid bit.
  - ready[k] = !valid[k] || ready[k+1]; ready[LAT] = m_tready.
  - A level loads when ready[k] is 1 and holds otherwise. There is no bubble insertion, and order is preserved.
- Output conversion, applied in the last level (the same cycle the last sum is formed):
  - OUT_WIDTH >= FW: extend the sum (sign or zero per SIGNED); m_tuser = 0.
  - OUT_WIDTH < FW, SATURATE=0: m_tdata = sum[OUT_WIDTH-1:0]. m_tuser = 1 iff the FW value is not representable in OUT_WIDTH (signed or unsigned range per SIGNED).
  - OUT_WIDTH < FW, SATURATE=1:
    - Unsigned: values above 2^OUT_WIDTH-1 clip to that value.
    - Signed: clip to 2^(OUT_WIDTH-1)-1 or -2^(OUT_WIDTH-1).
    - m_tuser = 1 when clipped.
- m_tdata and m_tuser are stable while m_tvalid=1 and m_tready=0.

## Timing
- Reset (aresetn=0 sampled at an edge):
  - All level valids clear.
  - m_tvalid=0, m_tdata=0, m_tuser=0.
  - s_tready=0 while aresetn=0.
- Reset mid-stream: in-flight transactions are discarded with no partial output. In the first cycle after release, s_tready may assert if all s_tvalid are high.
- Latency: a join handshake at edge T produces m_tvalid=1 in the cycle after edge T+LAT-1, i.e. LAT cycles after acceptance. LAT is 1 for N=2, 2 for N=3..4, 3 for N=5..8.
- Throughput: one transaction per cycle with m_tready held at 1.
- Backpressure:
  - With m_tready=0, up to LAT transactions are buffered.
  - s_tready drops in the same cycle the pipeline is full.
  - It reasserts combinationally the cycle m_tready returns to 1.
- Simultaneous events: an output handshake and a new join in the same cycle on a full pipeline are both accepted, because ready propagates from m_tready.

## Test plan
- Basic sum: N=4, IN=8, unsigned, default OUT=10. Operands 1,2,3,4 all valid at cycle 0 -> m_tdata=10, m_tuser=0, m_tvalid at cycle 2.
- Signed saturation: N=4, IN=8, SIGNED=1, SATURATE=1, OUT=8.
  - Operands 100,100,100,100 -> m_tdata=127, m_tuser=1.
  - Operands -100 x4 -> -128, m_tuser=1.
  - Operands 10,-5,3,2 -> 10, m_tuser=0.
- Unsigned wrap: N=4, IN=8, SATURATE=0, OUT=8. Operands 200 x4 -> m_tdata=32 (800 mod 256), m_tuser=1.
- Join stall: N=3. s_tvalid=3'b011 for 10 cycles -> s_tready stays 0 and no output. Raising bit 2 gives one handshake; the result equals the sum of the held operands.
- Backpressure: N=8, 20 back-to-back transactions with incrementing operands; m_tready toggles randomly, including a 5-cycle low.
  - All 20 sums arrive in order with none lost or duplicated.
  - s_tready=0 only when 3 transactions are held.
  - Output data is stable while stalled.
- Reset mid-stream: N=4. Assert aresetn=0 for 1 cycle while 2 transactions are in flight -> m_tvalid=0 the next cycle and those sums never appear. A fresh transaction after release yields the correct sum at LAT=2.
